trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_pkg.sv | 14 +
 rtl/trap_ctrl_if.sv | 36 +++
 rtl/trap_ctrl.sv | 69 ++++++
 tb/tb_trap_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: cause codes and state encodings shared by the trap controller
package trap_ctrl_pkg;
  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;
  typedef enum logic [2:0] {
    TRAP_ST_IDLE  = 3'd0,
    TRAP_ST_FLUSH = 3'd1,
    TRAP_ST_SAVE  = 3'd2,
    TRAP_ST_JUMP  = 3'd3,
    TRAP_ST_RET   = 3'd4
  } trap_state_e;
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: decode/CSR/fetch signals of the trap controller; mcause ports exist only with TRAP_CTRL_MCAUSE_EN
interface trap_ctrl_if;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        illegal_i;
  logic        ebreak_i;
  logic        ecall_i;
  logic        mret_i;
  logic        irq_i;
  logic        mie_i;
  logic [31:0] epc_i;
  logic        save_epc_o;
  logic [31:0] epc_pc_o;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
`ifdef TRAP_CTRL_MCAUSE_EN
  logic [31:0] mcause_o;
  logic        mcause_we_o;
`endif
  modport master (
    input  instr_valid_i, pc_i, illegal_i, ebreak_i, ecall_i, mret_i, irq_i, mie_i, epc_i,
`ifdef TRAP_CTRL_MCAUSE_EN
    output mcause_o, mcause_we_o,
`endif
    output save_epc_o, epc_pc_o, flush_o, stall_o, redirect_o, redirect_pc_o
  );
  modport slave (
    output instr_valid_i, pc_i, illegal_i, ebreak_i, ecall_i, mret_i, irq_i, mie_i, epc_i,
`ifdef TRAP_CTRL_MCAUSE_EN
    input  mcause_o, mcause_we_o,
`endif
    input  save_epc_o, epc_pc_o, flush_o, stall_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer (flush, EPC save, redirect); TRAP_CTRL_MCAUSE_EN adds mcause outputs
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC = 32'h0000_0010,
  parameter int RESET_PC_UNUSED_W = 32
) (
  input logic clk,
  input logic rst_n,
  trap_ctrl_if.master bus
);
  trap_state_e state, state_nx;
  logic [RESET_PC_UNUSED_W-1:0] pc_q;
  logic trap, ret;
`ifdef TRAP_CTRL_MCAUSE_EN
  logic [31:0] cause, cause_q;
`endif
  // priority encode decode-stage events: illegal > ebreak > ecall > irq > mret
  always_comb begin
    trap = bus.instr_valid_i & (bus.illegal_i | bus.ebreak_i | bus.ecall_i | (bus.irq_i & bus.mie_i));
    ret  = bus.instr_valid_i & bus.mret_i & ~trap;
`ifdef TRAP_CTRL_MCAUSE_EN
    cause = bus.illegal_i ? CAUSE_ILLEGAL :
            bus.ebreak_i  ? CAUSE_EBREAK  :
            bus.ecall_i   ? CAUSE_ECALL   : CAUSE_MEXT_IRQ;
`endif
  end
  // state register plus the faulting PC/cause captured when a trap is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TRAP_ST_IDLE;
      pc_q  <= '0;
`ifdef TRAP_CTRL_MCAUSE_EN
      cause_q <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == TRAP_ST_IDLE && trap) begin
        pc_q <= bus.pc_i;
`ifdef TRAP_CTRL_MCAUSE_EN
        cause_q <= cause;
`endif
      end
    end
  end
  // next state: events only matter in IDLE, every other state advances unconditionally
  always_comb begin
    state_nx = TRAP_ST_IDLE;
    unique case (state)
      TRAP_ST_IDLE:  state_nx = trap ? TRAP_ST_FLUSH : ret ? TRAP_ST_RET : TRAP_ST_IDLE;
      TRAP_ST_FLUSH: state_nx = TRAP_ST_SAVE;
      TRAP_ST_SAVE:  state_nx = TRAP_ST_JUMP;
      default:       state_nx = TRAP_ST_IDLE;
    endcase
  end
  // outputs decoded purely from registered state (epc_i only feeds the mret target)
  always_comb begin
    bus.flush_o       = state == TRAP_ST_FLUSH || state == TRAP_ST_RET;
    bus.stall_o       = state == TRAP_ST_FLUSH || state == TRAP_ST_SAVE || state == TRAP_ST_JUMP;
    bus.save_epc_o    = state == TRAP_ST_SAVE;
    bus.redirect_o    = state == TRAP_ST_JUMP || state == TRAP_ST_RET;
    bus.redirect_pc_o = state == TRAP_ST_JUMP ? MTVEC : state == TRAP_ST_RET ? bus.epc_i : 32'h0;
    bus.epc_pc_o      = pc_q;
`ifdef TRAP_CTRL_MCAUSE_EN
    bus.mcause_we_o   = state == TRAP_ST_SAVE;
    bus.mcause_o      = cause_q;
`endif
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  trap_ctrl_if bus ();
  trap_ctrl #(.MTVEC(32'h0000_0010), .RESET_PC_UNUSED_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] fssr, input logic [31:0] rpc, input logic [31:0] epc);
    chk({tag, " flush/stall/save/redir"}, {28'h0, bus.flush_o, bus.stall_o, bus.save_epc_o, bus.redirect_o}, {28'h0, fssr});
    chk({tag, " redirect_pc"}, bus.redirect_pc_o, rpc);
    chk({tag, " epc_pc"}, bus.epc_pc_o, epc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.instr_valid_i = 1'b0;
    bus.illegal_i = 1'b0;
    bus.ebreak_i = 1'b0;
    bus.ecall_i = 1'b0;
    bus.mret_i = 1'b0;
  endtask
  initial begin
    clr();
    bus.pc_i = 32'h0;
    bus.irq_i = 1'b0;
    bus.mie_i = 1'b0;
    bus.epc_i = 32'h0;
    #2;
    chk_out("reset", 4'b0000, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 32'h0, 32'h0);
    // 1: illegal instruction trap
    bus.instr_valid_i = 1'b1; bus.illegal_i = 1'b1; bus.pc_i = 32'h104;
    tick(); clr();
    chk_out("ill T+1", 4'b1100, 32'h0, 32'h104);
    tick();
    chk_out("ill T+2", 4'b0110, 32'h0, 32'h104);
    tick();
    chk_out("ill T+3", 4'b0101, 32'h10, 32'h104);
    tick();
    chk_out("ill T+4", 4'b0000, 32'h0, 32'h104);
    // 2: interrupt trap, then masked interrupt
    bus.instr_valid_i = 1'b1; bus.irq_i = 1'b1; bus.mie_i = 1'b1; bus.pc_i = 32'h200;
    tick(); clr(); bus.irq_i = 1'b0;
    chk_out("irq T+1", 4'b1100, 32'h0, 32'h200);
    tick();
    chk_out("irq T+2", 4'b0110, 32'h0, 32'h200);
`ifdef TRAP_CTRL_MCAUSE_EN
    chk("irq mcause", bus.mcause_o, 32'h8000_000B);
    chk("irq mcause_we", {31'h0, bus.mcause_we_o}, 32'h1);
`endif
    tick();
    chk_out("irq T+3", 4'b0101, 32'h10, 32'h200);
    tick();
    chk_out("irq T+4", 4'b0000, 32'h0, 32'h200);
    bus.instr_valid_i = 1'b1; bus.irq_i = 1'b1; bus.mie_i = 1'b0; bus.pc_i = 32'h280;
    tick();
    chk_out("irq masked 1", 4'b0000, 32'h0, 32'h200);
    tick();
    chk_out("irq masked 2", 4'b0000, 32'h0, 32'h200);
    clr(); bus.irq_i = 1'b0;
    // 3: mret redirects to epc_i
    bus.instr_valid_i = 1'b1; bus.mret_i = 1'b1; bus.epc_i = 32'h204;
    tick(); clr();
    chk_out("mret T+1", 4'b1001, 32'h204, 32'h200);
    tick();
    chk_out("mret T+2", 4'b0000, 32'h0, 32'h200);
    // 4: ecall beats irq; CSR clears MIE at save so held irq does not re-enter
    bus.instr_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.irq_i = 1'b1; bus.mie_i = 1'b1; bus.mret_i = 1'b1; bus.pc_i = 32'h300;
    tick(); bus.ecall_i = 1'b0; bus.mret_i = 1'b0;
    chk_out("ecall T+1", 4'b1100, 32'h0, 32'h300);
    tick();
    chk_out("ecall T+2", 4'b0110, 32'h0, 32'h300);
`ifdef TRAP_CTRL_MCAUSE_EN
    chk("ecall mcause", bus.mcause_o, 32'd11);
`endif
    bus.mie_i = 1'b0;
    tick();
    chk_out("ecall T+3", 4'b0101, 32'h10, 32'h300);
    tick();
    chk_out("ecall no reentry 1", 4'b0000, 32'h0, 32'h300);
    tick();
    chk_out("ecall no reentry 2", 4'b0000, 32'h0, 32'h300);
    clr(); bus.irq_i = 1'b0;
    // 5: ebreak during FLUSH is ignored
    bus.instr_valid_i = 1'b1; bus.ebreak_i = 1'b1; bus.pc_i = 32'h400;
    tick();
    chk_out("ebreak T+1", 4'b1100, 32'h0, 32'h400);
    bus.pc_i = 32'h500;
    tick(); clr();
    chk_out("ebreak T+2", 4'b0110, 32'h0, 32'h400);
`ifdef TRAP_CTRL_MCAUSE_EN
    chk("ebreak mcause", bus.mcause_o, 32'd3);
`endif
    tick();
    chk_out("ebreak T+3", 4'b0101, 32'h10, 32'h400);
    tick();
    chk_out("ebreak T+4", 4'b0000, 32'h0, 32'h400);
    tick();
    chk_out("ebreak T+5", 4'b0000, 32'h0, 32'h400);
    // 6: reset asserted in SAVE aborts the sequence
    bus.instr_valid_i = 1'b1; bus.illegal_i = 1'b1; bus.pc_i = 32'h600;
    tick(); clr();
    tick();
    chk_out("rst pre SAVE", 4'b0110, 32'h0, 32'h600);
    rst_n = 1'b0;
    #1;
    chk_out("rst async", 4'b0000, 32'h0, 32'h0);
    tick();
    chk_out("rst held", 4'b0000, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_out("rst after 1", 4'b0000, 32'h0, 32'h0);
    tick();
    chk_out("rst after 2", 4'b0000, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
